// File: rtl/brick_pkg.sv
// Shared geometry, colour constants, hit FSM state encoding and index helpers
// for the brick-wall controller.
package brick_pkg;

    localparam int NB_COL            = 3;
    localparam int NB_ROW            = 6;
    localparam int LARGEUR_BRIQUE    = 210;
    localparam int HAUTEUR_BRIQUE    = 80;
    localparam int MARGE_X           = 5;
    localparam int LARGEUR_ECRAN     = 640;
    localparam int HAUTEUR_ECRAN     = 480;
    localparam int INTERVALLE_BRIQUE = 1;
    localparam int COULEUR_BRIQUE    = 20;
    localparam int NB_BRICKS         = NB_COL * NB_ROW;

    localparam int COL_W = 2;
    localparam int ROW_W = 3;
    localparam int IDX_W = 5;
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DECODE  = 3'd1,
        APPLY   = 3'd2,
        ACK     = 3'd3,
        RELEASE = 3'd4
    } hit_state_e;

    function automatic logic [IDX_W-1:0] brick_index(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
        return IDX_W'(int'(row) * NB_COL + int'(col));
    endfunction

    // Top row is worth the most points.
    function automatic logic [15:0] brick_points(input logic [ROW_W-1:0] row);
        return 16'(NB_ROW - int'(row));
    endfunction

endpackage

// File: rtl/brick_wall_ctrl_locate.sv
// Combinational screen point -> brick cell locator, built from comparisons only.
module brick_locate
    import brick_pkg::*;
(
    input  logic [10:0]      x,
    input  logic [10:0]      y,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             valid,
    output logic             in_gap
);

    logic [11:0] x_s;
    logic [11:0] y_s;
    logic        col_hit_s;
    logic        row_hit_s;
    logic        col_gap_s;
    logic        row_gap_s;

    assign x_s = {1'b0, x};
    assign y_s = {1'b0, y};

    // Column search: each cell spans [lo, hi), gap is the last pixels before hi.
    always_comb begin
        col       = '0;
        col_hit_s = 1'b0;
        col_gap_s = 1'b0;
        for (int k = 0; k < NB_COL; k++) begin
            col       = ((x_s >= 12'(MARGE_X + k * LARGEUR_BRIQUE)) &&
                         (x_s <  12'(MARGE_X + (k + 1) * LARGEUR_BRIQUE))) ? COL_W'(k) : col;
            col_gap_s = ((x_s >= 12'(MARGE_X + (k + 1) * LARGEUR_BRIQUE - INTERVALLE_BRIQUE)) &&
                         (x_s <  12'(MARGE_X + (k + 1) * LARGEUR_BRIQUE))) ? 1'b1 : col_gap_s;
            col_hit_s = ((x_s >= 12'(MARGE_X + k * LARGEUR_BRIQUE)) &&
                         (x_s <  12'(MARGE_X + (k + 1) * LARGEUR_BRIQUE))) ? 1'b1 : col_hit_s;
        end
    end

    // Row search, same scheme with no vertical margin.
    always_comb begin
        row       = '0;
        row_hit_s = 1'b0;
        row_gap_s = 1'b0;
        for (int r = 0; r < NB_ROW; r++) begin
            row       = ((y_s >= 12'(r * HAUTEUR_BRIQUE)) &&
                         (y_s <  12'((r + 1) * HAUTEUR_BRIQUE))) ? ROW_W'(r) : row;
            row_gap_s = ((y_s >= 12'((r + 1) * HAUTEUR_BRIQUE - INTERVALLE_BRIQUE)) &&
                         (y_s <  12'((r + 1) * HAUTEUR_BRIQUE))) ? 1'b1 : row_gap_s;
            row_hit_s = ((y_s >= 12'(r * HAUTEUR_BRIQUE)) &&
                         (y_s <  12'((r + 1) * HAUTEUR_BRIQUE))) ? 1'b1 : row_hit_s;
        end
    end

    assign valid  = (x_s < 12'(LARGEUR_ECRAN)) && (y_s < 12'(HAUTEUR_ECRAN)) && col_hit_s && row_hit_s;
    assign in_gap = col_gap_s | row_gap_s;

endmodule

// File: rtl/brick_wall_ctrl.sv
// Brick-wall state, pixel colouring and collision hit servicing.
// Optional BRICK_SCORE_EN adds a saturating per-brick score.
module brick_wall_ctrl
    import brick_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        new_level,
    input  logic [10:0] hpos,
    input  logic [10:0] vpos,
    input  logic        hit_req,
    input  logic [10:0] hit_x,
    input  logic [10:0] hit_y,
    output logic        hit_ack,
    output logic        hit_brick,
    output logic [4:0]  couleur,
    output logic [4:0]  bricks_left,
    output logic        level_clear,
    output logic [15:0] score
);

    hit_state_e           state_r;
    logic [NB_BRICKS-1:0] bitmap_r;
    logic [CNT_W-1:0]     bricks_left_r;
    logic [10:0]          hx_r;
    logic [10:0]          hy_r;
    logic [IDX_W-1:0]     hit_idx_r;
    logic                 hit_valid_r;
    logic                 hit_ack_r;
    logic                 hit_brick_r;
    logic                 level_clear_r;
    logic [4:0]           couleur_r;

    logic [COL_W-1:0]     pix_col_s;
    logic [ROW_W-1:0]     pix_row_s;
    logic                 pix_valid_s;
    logic                 pix_gap_s;
    logic [IDX_W-1:0]     pix_idx_s;
    logic [COL_W-1:0]     hit_col_s;
    logic [ROW_W-1:0]     hit_row_s;
    logic                 hit_valid_s;
    logic                 apply_kill_s;

    brick_locate u_pix_locate (
        .x      (hpos),
        .y      (vpos),
        .col    (pix_col_s),
        .row    (pix_row_s),
        .valid  (pix_valid_s),
        .in_gap (pix_gap_s)
    );

    // The gap is part of the brick for collisions, so its flag is not needed here.
    brick_locate u_hit_locate (
        .x      (hx_r),
        .y      (hy_r),
        .col    (hit_col_s),
        .row    (hit_row_s),
        .valid  (hit_valid_s),
        .in_gap ()
    );

    assign pix_idx_s    = brick_index(pix_row_s, pix_col_s);
    assign apply_kill_s = (state_r == APPLY) && !new_level && hit_valid_r &&
                          bitmap_r[hit_idx_r] && (bricks_left_r != 5'd0);

    // Pixel colour, one clock of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            couleur_r <= 5'd0;
        end else if (pix_valid_s && !pix_gap_s && bitmap_r[pix_idx_s]) begin
            couleur_r <= 5'(COULEUR_BRIQUE);
        end else begin
            couleur_r <= 5'd0;
        end
    end

    // Hit FSM plus wall bitmap and live count; new_level wins over APPLY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            bitmap_r      <= {NB_BRICKS{1'b1}};
            bricks_left_r <= CNT_W'(NB_BRICKS);
            hx_r          <= 11'd0;
            hy_r          <= 11'd0;
            hit_idx_r     <= '0;
            hit_valid_r   <= 1'b0;
            hit_ack_r     <= 1'b0;
            hit_brick_r   <= 1'b0;
        end else begin
            if (new_level) begin
                bitmap_r      <= {NB_BRICKS{1'b1}};
                bricks_left_r <= CNT_W'(NB_BRICKS);
            end else if (apply_kill_s) begin
                bitmap_r[hit_idx_r] <= 1'b0;
                bricks_left_r       <= bricks_left_r - 5'd1;
            end else begin
                bricks_left_r <= bricks_left_r;
            end

            case (state_r)
                IDLE: begin
                    if (hit_req) begin
                        hx_r    <= hit_x;
                        hy_r    <= hit_y;
                        state_r <= DECODE;
                    end
                end
                DECODE: begin
                    hit_idx_r   <= brick_index(hit_row_s, hit_col_s);
                    hit_valid_r <= hit_valid_s;
                    state_r     <= APPLY;
                end
                APPLY: begin
                    hit_ack_r   <= 1'b1;
                    hit_brick_r <= apply_kill_s;
                    state_r     <= ACK;
                end
                ACK: begin
                    hit_ack_r   <= 1'b0;
                    hit_brick_r <= 1'b0;
                    state_r     <= RELEASE;
                end
                RELEASE: begin
                    if (!hit_req) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    hit_ack_r   <= 1'b0;
                    hit_brick_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Sticky wall-empty flag, follows the count by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_clear_r <= 1'b0;
        end else if (new_level) begin
            level_clear_r <= 1'b0;
        end else if (bricks_left_r == 5'd0) begin
            level_clear_r <= 1'b1;
        end else begin
            level_clear_r <= level_clear_r;
        end
    end

`ifdef BRICK_SCORE_EN
    logic [ROW_W-1:0] hit_row_r;
    logic [15:0]      score_r;
    logic [16:0]      score_sum_s;

    assign score_sum_s = {1'b0, score_r} + {1'b0, brick_points(hit_row_r)};

    // Row of the captured hit, kept for scoring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_row_r <= '0;
        end else if (state_r == DECODE) begin
            hit_row_r <= hit_row_s;
        end else begin
            hit_row_r <= hit_row_r;
        end
    end

    // Saturating score, untouched by new_level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_r <= 16'd0;
        end else if (apply_kill_s) begin
            score_r <= score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
        end else begin
            score_r <= score_r;
        end
    end

    assign score = score_r;
`else
    assign score = 16'd0;
`endif

    assign hit_ack     = hit_ack_r;
    assign hit_brick   = hit_brick_r;
    assign couleur     = couleur_r;
    assign bricks_left = bricks_left_r;
    assign level_clear = level_clear_r;

endmodule
